// File: rtl/baccarat_deal_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : baccarat_deal_fsm
//  Description : Deal sequencer for the baccarat card datapath. Steps the
//                four opening cards one per step pulse, applies the natural
//                and third-card rules, and drives done and the win lights.
//  Revision    : 1.0  initial release
// ============================================================================
module baccarat_deal_fsm #(
  parameter int NATURAL_MIN      = 8,
  parameter int PLAYER_STAND_MIN = 6
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       step,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  localparam logic [3:0] C_S_P1     = 4'd0;
  localparam logic [3:0] C_S_D1     = 4'd1;
  localparam logic [3:0] C_S_P2     = 4'd2;
  localparam logic [3:0] C_S_D2     = 4'd3;
  localparam logic [3:0] C_S_EVAL   = 4'd4;
  localparam logic [3:0] C_S_P3     = 4'd5;
  localparam logic [3:0] C_S_EVAL_D = 4'd6;
  localparam logic [3:0] C_S_D3     = 4'd7;
  localparam logic [3:0] C_S_RESULT = 4'd8;

  localparam logic [3:0] C_NATURAL_MIN      = 4'(NATURAL_MIN);
  localparam logic [3:0] C_PLAYER_STAND_MIN = 4'(PLAYER_STAND_MIN);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] w_p3v;
  logic       w_dealer_draw;
  logic       w_natural;
  logic       w_step_ok;

  assign w_step_ok = step & resetb;
  assign w_natural = (pscore >= C_NATURAL_MIN) || (dscore >= C_NATURAL_MIN);

  // Baccarat value of the player's third card: picture cards and bad codes count 0
  always_comb begin
    w_p3v = 4'd0;
    if ((pcard3 >= 4'd1) && (pcard3 <= 4'd9)) begin
      w_p3v = pcard3;
    end
  end

  // Dealer tableau after the player has drawn a third card
  always_comb begin
    w_dealer_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_dealer_draw = 1'b1;
      4'd3:             w_dealer_draw = (w_p3v != 4'd8);
      4'd4:             w_dealer_draw = (w_p3v >= 4'd2) && (w_p3v <= 4'd7);
      4'd5:             w_dealer_draw = (w_p3v >= 4'd4) && (w_p3v <= 4'd7);
      4'd6:             w_dealer_draw = (w_p3v >= 4'd6) && (w_p3v <= 4'd7);
      default:          w_dealer_draw = 1'b0;
    endcase
  end

  // Next-state logic: one state per step pulse, RESULT holds until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_S_P1:     if (step) state_d = C_S_D1;
      C_S_D1:     if (step) state_d = C_S_P2;
      C_S_P2:     if (step) state_d = C_S_D2;
      C_S_D2:     if (step) state_d = C_S_EVAL;
      C_S_EVAL: begin
        if (step) begin
          if (w_natural) begin
            state_d = C_S_RESULT;
          end else if (pscore < C_PLAYER_STAND_MIN) begin
            state_d = C_S_P3;
          end else if (dscore <= 4'd5) begin
            state_d = C_S_D3;
          end else begin
            state_d = C_S_RESULT;
          end
        end
      end
      C_S_P3:     if (step) state_d = C_S_EVAL_D;
      C_S_EVAL_D: if (step) state_d = w_dealer_draw ? C_S_D3 : C_S_RESULT;
      C_S_D3:     if (step) state_d = C_S_RESULT;
      C_S_RESULT: state_d = C_S_RESULT;
      // Unused encodings recover to the start of a round
      default:    state_d = C_S_P1;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q <= C_S_P1;
    end else begin
      state_q <= state_d;
    end
  end

  // Mealy load strobes and RESULT outputs, all forced low while in reset
  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    done             = 1'b0;
    if (resetb) begin
      load_pcard1 = w_step_ok && (state_q == C_S_P1);
      load_dcard1 = w_step_ok && (state_q == C_S_D1);
      load_pcard2 = w_step_ok && (state_q == C_S_P2);
      load_dcard2 = w_step_ok && (state_q == C_S_D2);
      load_pcard3 = w_step_ok && (state_q == C_S_P3);
      load_dcard3 = w_step_ok && (state_q == C_S_D3);
      if (state_q == C_S_RESULT) begin
        done             = 1'b1;
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/baccarat_deal_fsm.md
Name: baccarat_deal_fsm

Overview:
- Sequencer for the baccarat card datapath. It steps the deal of player and dealer cards one card per step, applies the natural and third-card rules, and drives the win lights.
- Sits between the step/reset pushbuttons and the card/score registers that feed the 7-segment card and score displays.
- Consumes running scores and the player's third card code from the datapath; emits one-cycle load pulses per card register.

Parameters:
- NATURAL_MIN, 8, two-card score at or above which either hand ends the round (natural).
- PLAYER_STAND_MIN, 6, player two-card score at or above which the player stands.

Ports:
- slow_clock  input  1  single clock; all state changes on its rising edge.
- resetb  input  1  synchronous active-low reset.
- step  input  1  advance qualifier; FSM moves at most one state per cycle with step=1.
- pscore  input  4  player hand score, 0-9, combinational from datapath.
- dscore  input  4  dealer hand score, 0-9, combinational from datapath.
- pcard3  input  4  player third card code, 1-13 (A..K).
- load_pcard1, load_pcard2, load_pcard3  output  1 each  load strobes to player card registers.
- load_dcard1, load_dcard2, load_dcard3  output  1 each  load strobes to dealer card registers.
- player_win_light  output  1  player wins (or tie).
- dealer_win_light  output  1  dealer wins (or tie).
- done  output  1  round finished.

Behaviour:
- States: P1, D1, P2, D2, EVAL, P3, EVAL_D, D3, RESULT.
- Reset: if resetb=0 at a clock edge, state <= P1. All outputs are 0 in any cycle with resetb=0, regardless of state. Reset mid-round aborts the round; there is no residual state.
- Load strobes are Mealy: load_X = (state==X) & step & resetb. Each strobe is exactly one cycle per step pulse. The datapath captures the card on the same edge the FSM leaves X.
- step=0: state holds and all loads are 0.
- Fixed sequence with step=1: P1->D1->P2->D2->EVAL.
- EVAL with step=1, checked in priority order:
  - pscore>=NATURAL_MIN or dscore>=NATURAL_MIN -> RESULT.
  - Else pscore<PLAYER_STAND_MIN -> P3.
  - Else dscore<=5 -> D3.
  - Else -> RESULT.
- P3 with step=1: load_pcard3 pulses; -> EVAL_D.
- EVAL_D with step=1 uses p3v = card value of pcard3 (codes 10-13, 0, 14, 15 count as 0; 1-9 count face value). Draw (-> D3) when any of:
  - dscore<=2;
  - dscore==3 and p3v!=8;
  - dscore==4 and p3v in 2..7;
  - dscore==5 and p3v in 4..7;
  - dscore==6 and p3v in 6..7.
  - Otherwise -> RESULT.
- D3 with step=1: load_dcard3 pulses; -> RESULT.
- RESULT is terminal; step is ignored. Exit only via reset.
- Outputs in RESULT (combinational on current scores, so valid the cycle after the last load):
  - done=1.
  - player_win_light = pscore>=dscore.
  - dealer_win_light = dscore>=pscore.
  - Tie lights both.
- Outside RESULT: done and both lights are 0.
- EVAL and EVAL_D decide on the step edge using the scores present in that cycle. Both are always stable, because the last load happened at least one edge earlier.
- Score inputs 10-15 are illegal. They only need to produce a legal state transition; no particular one is required.
- State encoding is free. Unreachable encodings must go to P1 on the next edge.

Test Plan:
- Reset with resetb=0 for 2 cycles, then step pulses -> exactly one strobe per pulse in order load_pcard1, dcard1, pcard2, dcard2; no strobe on cycles with step=0; all outputs 0 during reset.
- Natural: pscore=8, dscore=3 at EVAL, step -> RESULT with no third-card loads; done=1, player_win_light=1, dealer_win_light=0.
- Player draws: pscore=4, dscore=3, pcard3=8 (p3v=8) -> load_pcard3 pulses, dealer stands, RESULT. Then pscore=2, dscore=3 -> dealer_win_light=1 only.
- Player draws: dscore=6, pcard3=12 (Q, p3v=0) -> dealer stands. Repeat with pcard3=7 -> load_dcard3 pulses, then RESULT.
- Player stands: pscore=7, dscore=5 -> skip P3, load_dcard3 pulses. Then pscore=7, dscore=7 -> both lights 1, done=1.
- Mid-round reset: resetb=0 during EVAL_D -> no load_dcard3. Next step after reset release -> load_pcard1 pulses and done=0.
